// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults, derived totals, coordinate type and flag bundle.
// Combinational definitions only.
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Bit order matches the {fs, active, vs, hs} bundle carried by the delay line.
  typedef struct packed {
    logic fs;
    logic active;
    logic vs;
    logic hs;
  } flags_t;

  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction
endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with synchronous active-low clear to RST_VAL.
// Latency: DEPTH cycles from d to q.
module sig_delay #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_timer.sv
// VGA raster counters with sync/blank/frame flags trailing x/y by LEAD cycles.
// frame_cnt updates on the frame wrap edge with no extra delay.
module vga_timer
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int LEAD     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       activevideo,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timer: line or frame total exceeds 10-bit counter range");
  end
  if (LEAD < 1 || LEAD > 4) begin : g_bad_lead
    $error("vga_timer: LEAD must be in 1..4");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      if (y == V_LAST) begin
        y         <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        y <= y + 10'd1;
      end
    end else begin
      x <= x + 10'd1;
    end
  end

  flags_t dec;
  flags_t dly;

  always_comb begin
    dec        = '0;
    dec.active = (x < H_ACT) && (y < V_ACT);
    dec.hs     = in_span(x, HS_START, HS_END);
    dec.vs     = in_span(y, VS_START, VS_END);
    dec.fs     = (x == '0) && (y == '0);
  end

  // First stage is the decode register; the rest stretch it to LEAD cycles.
  sig_delay #(
    .WIDTH  (4),
    .DEPTH  (LEAD),
    .RST_VAL(4'b0000)
  ) u_flag_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dec),
    .q    (dly)
  );

  assign hsync       = dly.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = dly.vs ? SYNC_POL : ~SYNC_POL;
  assign activevideo = dly.active;
  assign frame_start = dly.fs;
endmodule

// File: tb/tb_vga_timer.sv
// Scoreboarded bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_vga_timer;
  localparam int SX = 0, SY = 1, SH = 2, SV = 3, SA = 4, SF = 5, SC = 6, NF = 7, NV = 8;
  localparam logic [2:0] POLS = 3'b010;
  localparam int RA  = 4;
  localparam int RB  = 6;
  localparam int RC  = 5;
  localparam int RA2 = RA + 17904;
  localparam int END_EDGE = 19000;

  typedef struct {
    int    cyc;
    int    dut;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;
  int   fs_n [3];
  int   vs_n [3];

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic [9:0] x_o [3];
  logic [9:0] y_o [3];
  logic       hs_o [3];
  logic       vs_o [3];
  logic       av_o [3];
  logic       fs_o [3];
  logic [7:0] fc_o [3];

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  vga_timer #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .LEAD(2), .SYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .x(x_o[0]), .y(y_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
    .activevideo(av_o[0]), .frame_start(fs_o[0]), .frame_cnt(fc_o[0]));

  vga_timer #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .LEAD(4), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .x(x_o[1]), .y(y_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
    .activevideo(av_o[1]), .frame_start(fs_o[1]), .frame_cnt(fc_o[1]));

  vga_timer #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1),
              .V_BP(1), .LEAD(1), .SYNC_POL(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n[2]), .x(x_o[2]), .y(y_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
    .activevideo(av_o[2]), .frame_start(fs_o[2]), .frame_cnt(fc_o[2]));

  function automatic int sample(int d, int s);
    case (s)
      SX:      return int'(x_o[d]);
      SY:      return int'(y_o[d]);
      SH:      return int'(hs_o[d]);
      SV:      return int'(vs_o[d]);
      SA:      return int'(av_o[d]);
      SF:      return int'(fs_o[d]);
      SC:      return int'(fc_o[d]);
      NF:      return fs_n[d];
      default: return vs_n[d];
    endcase
  endfunction

  // Monitor: accumulate pulse/assert counts, then settle every expectation due this cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (fs_o[d] === 1'b1) fs_n[d]++;
      if (vs_o[d] === POLS[d]) vs_n[d]++;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        n_cmp++;
        if (sample(sb[i].dut, sb[i].sig) != sb[i].val) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", sb[i].name, sb[i].dut,
                   edges, sample(sb[i].dut, sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < edges) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d: check for cyc %0d was skipped", sb[i].name, sb[i].dut, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int d, input int c, input int s, input int v, input string n);
    exp_t e;
    e.cyc  = c;
    e.dut  = d;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    while (edges < n) @(negedge clk);
  endtask

  // r = sample holding (0,0) in the last reset cycle; 800-cycle line geometry.
  task automatic push_startup(input int d, input int r, input int l, input int pol);
    chk(d, r - 1, SX, 0, "rst_x");
    chk(d, r - 1, SY, 0, "rst_y");
    chk(d, r - 1, SH, 1 - pol, "rst_hsync");
    chk(d, r - 1, SV, 1 - pol, "rst_vsync");
    chk(d, r - 1, SA, 0, "rst_active");
    chk(d, r - 1, SF, 0, "rst_fs");
    chk(d, r - 1, SC, 0, "rst_fcnt");
    chk(d, r, SX, 0, "hold_x0");
    chk(d, r + 1, SX, 1, "first_adv_x");
    chk(d, r + l - 1, SF, 0, "fs_early");
    chk(d, r + l, SF, 1, "fs_at_lead");
    chk(d, r + l + 1, SF, 0, "fs_one_cycle");
    chk(d, r + l - 1, SA, 0, "active_early");
    chk(d, r + l, SA, 1, "active_rise");
    chk(d, r + 640 + l - 1, SA, 1, "active_last");
    chk(d, r + 640 + l, SA, 0, "active_fall");
    chk(d, r + 656 + l - 1, SH, 1 - pol, "hsync_pre");
    chk(d, r + 656 + l, SH, pol, "hsync_assert");
    chk(d, r + 752 + l - 1, SH, pol, "hsync_last");
    chk(d, r + 752 + l, SH, 1 - pol, "hsync_release");
    chk(d, r + 799, SX, 799, "line_end_x");
    chk(d, r + 799, SY, 0, "line_end_y");
    chk(d, r + 800, SX, 0, "line_wrap_x");
    chk(d, r + 800, SY, 1, "line_wrap_y");
  endtask

  // Ten-line frame: vsync on lines 6..7, frame length 8000 cycles.
  task automatic push_frame(input int d, input int r, input int l, input int pol);
    chk(d, r + 4800 + l - 1, SV, 1 - pol, "vsync_pre");
    chk(d, r + 4800 + l, SV, pol, "vsync_assert");
    chk(d, r + 6400 + l - 1, SV, pol, "vsync_last");
    chk(d, r + 6400 + l, SV, 1 - pol, "vsync_release");
    chk(d, r + 7999, SX, 799, "frame_end_x");
    chk(d, r + 7999, SY, 9, "frame_end_y");
    chk(d, r + 7999, SC, 0, "fcnt_before_wrap");
    chk(d, r + 8000, SX, 0, "frame_wrap_x");
    chk(d, r + 8000, SY, 0, "frame_wrap_y");
    chk(d, r + 8000, SC, 1, "fcnt_after_wrap");
    chk(d, r + 8000, NV, 1600, "vsync_assert_cycles");
    chk(d, r + 8000 + l - 1, NF, 1, "fs_count_frame1");
    chk(d, r + 8000 + l, NF, 2, "fs_count_frame2");
    chk(d, r + 8000 + l, SF, 1, "fs_frame2");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      fs_n[d]  = 0;
      vs_n[d]  = 0;
    end

    push_startup(0, RA, 2, 0);
    push_frame(0, RA, 2, 0);
    chk(0, RA + 16001, NF, 2, "fs_count_gap");
    chk(0, RA + 16002, NF, 3, "fs_count_frame3");
    chk(0, RA + 16000, NV, 3200, "vsync_cycles_2f");

    push_startup(1, RB, 4, 1);
    push_frame(1, RB, 4, 1);

    chk(2, RC - 1, SX, 0, "tiny_rst_x");
    chk(2, RC - 1, SH, 1, "tiny_rst_hsync");
    chk(2, RC - 1, SF, 0, "tiny_rst_fs");
    chk(2, RC, SF, 0, "tiny_fs_early");
    chk(2, RC + 1, SF, 1, "tiny_fs_lead1");
    chk(2, RC + 1, SA, 1, "tiny_active_rise");
    chk(2, RC + 4, SA, 1, "tiny_active_last");
    chk(2, RC + 5, SA, 0, "tiny_active_fall");
    chk(2, RC + 5, SH, 1, "tiny_hsync_pre");
    chk(2, RC + 6, SH, 0, "tiny_hsync_assert");
    chk(2, RC + 7, SH, 1, "tiny_hsync_release");
    chk(2, RC + 6, SX, 6, "tiny_line_end_x");
    chk(2, RC + 7, SX, 0, "tiny_wrap_x");
    chk(2, RC + 7, SY, 1, "tiny_wrap_y");
    chk(2, RC + 21, SV, 1, "tiny_vsync_pre");
    chk(2, RC + 22, SV, 0, "tiny_vsync_assert");
    chk(2, RC + 28, SV, 0, "tiny_vsync_last");
    chk(2, RC + 29, SV, 1, "tiny_vsync_release");
    chk(2, RC + 34, SY, 4, "tiny_frame_end_y");
    chk(2, RC + 35, SC, 1, "tiny_fcnt_1");
    chk(2, RC + 35, SY, 0, "tiny_frame_wrap_y");
    chk(2, RC + 36, SF, 1, "tiny_fs_frame2");
    chk(2, RC + 8925, SC, 255, "fcnt_255");
    chk(2, RC + 8959, SC, 255, "fcnt_255_hold");
    chk(2, RC + 8960, SC, 0, "fcnt_wrap_0");
    chk(2, RC + 8960, SF, 0, "fs_before_wrap_pulse");
    chk(2, RC + 8961, SF, 1, "fs_after_cnt_wrap");
    chk(2, RC + 8961, NF, 257, "fs_count_257");

    wait_edges(RA);
    rst_n[0] = 1'b1;
    wait_edges(RC);
    rst_n[2] = 1'b1;
    wait_edges(RB);
    rst_n[1] = 1'b1;

    // Mid-frame reset on dut_a at (300,2) of its third frame.
    wait_edges(RA + 17800);
    chk(0, RA + 17900, SX, 300, "pre_mid_x");
    chk(0, RA + 17900, SY, 2, "pre_mid_y");
    chk(0, RA + 17900, SC, 2, "pre_mid_fcnt");
    chk(0, RA + 17900, SA, 1, "pre_mid_active");
    chk(0, RA + 17901, SX, 0, "mid_rst_x");
    chk(0, RA + 17901, SY, 0, "mid_rst_y");
    chk(0, RA + 17901, SC, 0, "mid_rst_fcnt");
    chk(0, RA + 17901, SA, 0, "mid_rst_active");
    chk(0, RA + 17901, SF, 0, "mid_rst_fs");
    chk(0, RA + 17901, SH, 1, "mid_rst_hsync");
    chk(0, RA + 17901, SV, 1, "mid_rst_vsync");
    push_startup(0, RA2, 2, 0);
    chk(0, RA2 + 2, NF, 4, "fs_count_after_rerelease");

    wait_edges(RA + 17900);
    rst_n[0] = 1'b0;
    wait_edges(RA2);
    rst_n[0] = 1'b1;

    wait_edges(END_EDGE);
    @(posedge clk);
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s dut%0d: cyc %0d never reached", sb[0].name, sb[0].dut, sb[0].cyc);
      sb.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
